// File: rtl/spi_ram_burst.sv
// RAM back-end for the SPI slave: decodes {cmd, field} words into address
// set-up, writes and multi-beat read bursts with a valid/ready output.
module spi_ram_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int FIELD_W   = 8,
  parameter bit AUTO_INC  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [FIELD_W+1:0] din,
  input  logic               tx_ready,
  output logic               tx_valid,
  output logic [DATA_W-1:0]  dout,
  output logic               busy,
  output logic               cmd_drop,
  output logic               addr_err
);

  typedef enum logic [1:0] {
    CMD_SET_WR = 2'b00,
    CMD_WRITE  = 2'b01,
    CMD_SET_RD = 2'b10,
    CMD_BURST  = 2'b11
  } cmd_t;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [FIELD_W:0]   DEPTH_F   = (FIELD_W + 1)'(MEM_DEPTH);

  state_t              state;
  cmd_t                cmd;
  logic [FIELD_W-1:0]  field;
  logic [ADDR_W-1:0]   field_addr;
  logic                field_in_range;
  logic                mem_we;
  logic                beat_done;
  logic [ADDR_W-1:0]   addr_wr;
  logic [ADDR_W-1:0]   addr_rd;
  logic [FIELD_W-1:0]  beats_left;
  logic [DATA_W-1:0]   mem [MEM_DEPTH];

  assign cmd            = cmd_t'(din[FIELD_W+1:FIELD_W]);
  assign field          = din[FIELD_W-1:0];
  assign field_addr     = field[ADDR_W-1:0];
  // The full field is range-checked, not just the address bits.
  assign field_in_range = ({1'b0, field} < DEPTH_F);
  assign beat_done      = tx_valid && tx_ready;
  assign mem_we         = !rst && (state == IDLE) && rx_valid && (cmd == CMD_WRITE);

  // Wraps explicitly so that non-power-of-two depths stay in range.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  // NOTE: the array has no reset so it maps onto RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_wr] <= field[DATA_W-1:0];
  end

  // NOTE: every register here uses <= so all reads see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_valid   <= 1'b0;
      dout       <= '0;
      busy       <= 1'b0;
      cmd_drop   <= 1'b0;
      addr_err   <= 1'b0;
      addr_wr    <= '0;
      addr_rd    <= '0;
      beats_left <= '0;
    end else begin
      cmd_drop <= rx_valid && (state == BURST);
      addr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            case (cmd)
              CMD_SET_WR: begin
                if (field_in_range) addr_wr <= field_addr;
                else                addr_err <= 1'b1;
              end
              CMD_WRITE: begin
                if (AUTO_INC) addr_wr <= next_addr(addr_wr);
              end
              CMD_SET_RD: begin
                if (field_in_range) addr_rd <= field_addr;
                else                addr_err <= 1'b1;
              end
              CMD_BURST: begin
                dout       <= mem[addr_rd];
                tx_valid   <= 1'b1;
                busy       <= 1'b1;
                beats_left <= field;
                state      <= BURST;
                if (AUTO_INC) addr_rd <= next_addr(addr_rd);
              end
              default: ;
            endcase
          end
        end
        BURST: begin
          if (beat_done) begin
            if (beats_left == '0) begin
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              // Prefetch the next word on the accepting edge: 1 beat/cycle.
              dout       <= mem[addr_rd];
              beats_left <= beats_left - FIELD_W'(1);
              if (AUTO_INC) addr_rd <= next_addr(addr_rd);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
